// File: rtl/mod_a_driver.sv
// -----------------------------------------------------------------------------
// mod_a_driver
//
// Initiator for the triggered-counter handshake. A start request runs a
// programmable number of rounds. In each round the block sends a one-cycle
// trigger to the counter unit, then waits for a rising edge on ok and captures
// the count the unit reports. Every wait has a timeout. The block reports the
// end of each sequence, the last captured count and whether a timeout occurred.
//
// Parameters
//   CNT_W       width of the count returned by the counter unit
//   TIMEOUT     cycles allowed for an ok rising edge after each trigger (2..255)
//
// Ports
//   clk         single clock; all state changes on the rising edge
//   rst         asynchronous, active-low reset
//   start       sequence request; sampled only in IDLE
//   runs        number of trigger rounds; latched when start is accepted
//   ok          completion from the unit; only a rising edge counts
//   count_a     count from the unit; captured when the ok rising edge is seen
//   trg_a       one-cycle trigger pulse to the unit
//   busy        high while a sequence is in progress (state != IDLE)
//   done        one-cycle pulse at the end of every accepted start
//   stop_val    count_a captured at the most recent completion
//   run_cnt     rounds completed in the current or last sequence
//   timeout_err sticky timeout flag; cleared by the next accepted start
// -----------------------------------------------------------------------------
module mod_a_driver #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       runs,
   input  logic             ok,
   input  logic [CNT_W-1:0] count_a,
   output logic             trg_a,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] stop_val,
   output logic [3:0]       run_cnt,
   output logic             timeout_err
);

   // TIMEOUT is at most 255, so an 8-bit timer is always wide enough.
   localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FIRE   = 3'd1,
      WAIT   = 3'd2,
      GAP    = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic       ok_q;
   logic [7:0] timer;
   logic [3:0] runs_lat;

   // Control strobes from the next-state logic to the datapath.
   logic       seq_clr;    // start accepted: clear run_cnt and timeout_err
   logic       runs_ld;    // start accepted with runs != 0: latch runs
   logic       tmr_clr;
   logic       tmr_inc;
   logic       capture;    // completion seen: take count_a, bump run_cnt
   logic       to_set;

   logic       ok_rise;
   logic [3:0] run_cnt_inc;

   // The level on ok is ignored. If ok is already high when a trigger is
   // issued, the unit has to drop it before a new completion can be detected.
   assign ok_rise     = ok & ~ok_q;
   assign run_cnt_inc = run_cnt + 4'd1;

   // These outputs are decoded from the state register only, so no input
   // reaches them combinationally.
   assign trg_a = (state == FIRE);
   assign done  = (state == FINISH);
   assign busy  = (state != IDLE);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Next-state and control decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      seq_clr   = 1'b0;
      runs_ld   = 1'b0;
      tmr_clr   = 1'b0;
      tmr_inc   = 1'b0;
      capture   = 1'b0;
      to_set    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               seq_clr = 1'b1;
               if (runs != 4'd0) begin
                  runs_ld   = 1'b1;
                  state_nxt = FIRE;
               end else begin
                  // Zero rounds: report completion without triggering.
                  state_nxt = FINISH;
               end
            end
         end
         FIRE: begin
            tmr_clr   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            tmr_inc = 1'b1;
            // A completion wins over a timeout in the same cycle.
            if (ok_rise) begin
               capture   = 1'b1;
               state_nxt = (run_cnt_inc == runs_lat) ? FINISH : GAP;
            end else if (timer == TMR_LAST) begin
               to_set    = 1'b1;
               state_nxt = FINISH;
            end
         end
         // One spare cycle keeps trigger pulses at least two cycles apart.
         GAP:     state_nxt = FIRE;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ok_q        <= 1'b0;
         timer       <= '0;
         runs_lat    <= '0;
         stop_val    <= '0;
         run_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         ok_q <= ok;

         if (tmr_clr)      timer <= '0;
         else if (tmr_inc) timer <= timer + 8'd1;

         if (runs_ld) runs_lat <= runs;

         // run_cnt never goes past the latched runs value, so it cannot wrap.
         if (seq_clr)      run_cnt <= '0;
         else if (capture) run_cnt <= run_cnt_inc;

         if (capture) stop_val <= count_a;

         if (seq_clr)     timeout_err <= 1'b0;
         else if (to_set) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mod_a_driver.sv
// -----------------------------------------------------------------------------
// tb_mod_a_driver
//
// Directed bench for mod_a_driver with CNT_W=4 and TIMEOUT=16. Inputs change
// 1 ns after each rising edge. Outputs are checked at that point, so each check
// sees the registered values that follow the edge just taken.
// -----------------------------------------------------------------------------
module tb_mod_a_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] runs;
   logic       ok;
   logic [3:0] count_a;
   logic       trg_a;
   logic       busy;
   logic       done;
   logic [3:0] stop_val;
   logic [3:0] run_cnt;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;
   int trg_cnt = 0;
   int done_cnt = 0;
   int t0;
   int d0;

   mod_a_driver #(.CNT_W(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .runs(runs), .ok(ok),
      .count_a(count_a), .trg_a(trg_a), .busy(busy), .done(done),
      .stop_val(stop_val), .run_cnt(run_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Count the trg_a and done pulses that are high at mid-cycle.
   always @(negedge clk) begin
      if (trg_a === 1'b1) trg_cnt++;
      if (done === 1'b1)  done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Call this in the FIRE cycle. It waits lat cycles, presents one ok pulse
   // with count v, and checks the capture. For the last round it then checks
   // the done/idle sequence; otherwise it checks GAP followed by the next FIRE.
   task automatic round(input int lat, input logic [3:0] v,
                        input int exp_cnt, input bit last);
      repeat (lat) tick();
      ok = 1'b1;
      count_a = v;
      tick();
      chk("cap_stop_val", stop_val, v);
      chk("cap_run_cnt", run_cnt, exp_cnt);
      chk("cap_done", done, last);
      chk("cap_trg_gap", trg_a, 0);
      ok = 1'b0;
      tick();
      if (last) begin
         chk("end_done_low", done, 0);
         chk("end_busy_low", busy, 0);
      end else begin
         chk("next_trg", trg_a, 1);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; runs = '0; ok = 1'b0; count_a = '0;
      #2;
      // Reset state
      chk("rst_trg", trg_a, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stop_val", stop_val, 0);
      chk("rst_run_cnt", run_cnt, 0);
      chk("rst_timeout", timeout_err, 0);
      do_reset();

      // Single round: ok rises 4 cycles after trg_a, count 4
      t0 = trg_cnt; d0 = done_cnt;
      start = 1'b1; runs = 4'd1;
      tick();
      start = 1'b0;
      chk("s1_fire_trg", trg_a, 1);
      chk("s1_fire_busy", busy, 1);
      round(4, 4'd4, 1, 1'b1);
      chk("s1_timeout", timeout_err, 0);
      chk("s1_trg_pulses", trg_cnt - t0, 1);
      chk("s1_done_pulses", done_cnt - d0, 1);

      // Multi-round: 3 rounds returning 4, 7, 4
      t0 = trg_cnt; d0 = done_cnt;
      start = 1'b1; runs = 4'd3;
      tick();
      start = 1'b0;
      chk("m_fire_trg", trg_a, 1);
      chk("m_run_cnt_cleared", run_cnt, 0);
      round(2, 4'd4, 1, 1'b0);
      round(3, 4'd7, 2, 1'b0);
      round(1, 4'd4, 3, 1'b1);
      chk("m_stop_val", stop_val, 4);
      chk("m_run_cnt", run_cnt, 3);
      chk("m_trg_pulses", trg_cnt - t0, 3);
      chk("m_done_pulses", done_cnt - d0, 1);

      // Timeout: runs=2, no ok at all
      d0 = done_cnt;
      start = 1'b1; runs = 4'd2;
      tick();
      start = 1'b0;
      chk("to_fire_trg", trg_a, 1);
      tick();                         // WAIT entry edge
      repeat (15) tick();
      chk("to_not_yet", timeout_err, 0);
      chk("to_no_done_yet", done, 0);
      tick();                         // 16 cycles after WAIT entry
      chk("to_err_set", timeout_err, 1);
      chk("to_done", done, 1);
      chk("to_run_cnt", run_cnt, 0);
      tick();
      chk("to_idle", busy, 0);
      chk("to_sticky", timeout_err, 1);
      chk("to_done_pulses", done_cnt - d0, 1);

      // Zero runs: done on the next cycle, no trigger, timeout_err cleared
      t0 = trg_cnt;
      start = 1'b1; runs = 4'd0;
      tick();
      start = 1'b0;
      chk("z_done", done, 1);
      chk("z_trg", trg_a, 0);
      chk("z_err_cleared", timeout_err, 0);
      chk("z_run_cnt", run_cnt, 0);
      tick();
      chk("z_done_low", done, 0);
      chk("z_no_trg", trg_cnt - t0, 0);

      // Stuck ok: held high from before start
      do_reset();
      ok = 1'b1;
      tick();
      start = 1'b1; runs = 4'd1;
      tick();
      start = 1'b0;
      chk("st_fire_trg", trg_a, 1);
      tick();
      repeat (15) tick();
      chk("st_not_yet", timeout_err, 0);
      tick();
      chk("st_err", timeout_err, 1);
      chk("st_done", done, 1);
      chk("st_stop_val", stop_val, 0);
      chk("st_run_cnt", run_cnt, 0);
      ok = 1'b0;
      tick();

      // Ignored start mid-WAIT with runs=2
      t0 = trg_cnt;
      start = 1'b1; runs = 4'd2;
      tick();
      start = 1'b0;
      chk("ig_fire_trg", trg_a, 1);
      tick();                         // WAIT
      start = 1'b1; runs = 4'd5;
      tick();
      start = 1'b0;
      chk("ig_still_wait", trg_a, 0);
      ok = 1'b1; count_a = 4'd9;
      tick();
      chk("ig_cap1_stop", stop_val, 9);
      chk("ig_cap1_cnt", run_cnt, 1);
      ok = 1'b0;
      tick();
      chk("ig_fire2", trg_a, 1);
      round(2, 4'd3, 2, 1'b1);
      chk("ig_run_cnt", run_cnt, 2);
      chk("ig_trg_pulses", trg_cnt - t0, 2);

      // Async reset in WAIT of a runs=3 sequence
      start = 1'b1; runs = 4'd3;
      tick();
      start = 1'b0;
      round(2, 4'd6, 1, 1'b0);        // ends in the second FIRE cycle
      tick();                         // WAIT
      chk("ar_pre_busy", busy, 1);
      chk("ar_pre_stop", stop_val, 6);
      d0 = done_cnt;
      #2 rst = 1'b0;
      #1;
      chk("ar_trg", trg_a, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_stop_val", stop_val, 0);
      chk("ar_run_cnt", run_cnt, 0);
      chk("ar_timeout", timeout_err, 0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("ar_idle", busy, 0);
      chk("ar_no_done", done_cnt - d0, 0);
      // After reset the block must accept a new start from IDLE.
      start = 1'b1; runs = 4'd1;
      tick();
      start = 1'b0;
      chk("ar_restart_trg", trg_a, 1);
      round(1, 4'd2, 1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
